// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and master identifiers for the two-master arbiter.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Address-phase owner; doubles as the arbiter FSM state (OWN0 = CPU, OWN1 = DMA).
  typedef enum logic {
    OWN0 = 1'b0,
    OWN1 = 1'b1
  } owner_e;

  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_DMA = 1'b1;

  // SEQ and BUSY continue a burst, so ownership must not move under them.
  function automatic logic is_burst_cont(input logic [1:0] htrans);
    return (htrans == HTRANS_SEQ) || (htrans == HTRANS_BUSY);
  endfunction

endpackage

// File: rtl/ahb_arb_prio.sv
// Combinational next-owner selection: burst lock, hold expiry, then priority.
module ahb_arb_prio
  import ahb_pkg::*;
#(
  parameter owner_e DEFAULT_OWNER = OWN0,
  parameter bit     RR_EN         = 1'b0
) (
  input  logic [1:0] req_i,
  input  owner_e     owner_i,
  input  logic       burst_lock_i,
  input  logic       hold_expired_i,
  output owner_e     next_owner_o
);

  owner_e other;
  logic   other_req;

  assign other     = owner_e'(~owner_i);
  assign other_req = (owner_i == OWN0) ? req_i[1] : req_i[0];

  // Pick the owner for the next address phase.
  always_comb begin
    // NOTE: default assigned first so every path drives the output and no latch is inferred.
    next_owner_o = owner_i;
    if (burst_lock_i) begin
      next_owner_o = owner_i;
    end else if (hold_expired_i && other_req) begin
      next_owner_o = other;
    end else if (RR_EN) begin
      // The current owner is the most recently served master, so it ranks lowest.
      if (&req_i)        next_owner_o = other;
      else if (req_i[0]) next_owner_o = OWN0;
      else if (req_i[1]) next_owner_o = OWN1;
      else               next_owner_o = DEFAULT_OWNER;
    end else begin
      // With only two masters, "owner still requests" is already covered by these two tests.
      if (req_i[0])      next_owner_o = OWN0;
      else if (req_i[1]) next_owner_o = OWN1;
      else               next_owner_o = DEFAULT_OWNER;
    end
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter (CPU = M0, DMA = M1) with pipelined address/data ownership.
module ahb_master_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned RR_EN          = 0,
  parameter int unsigned MAX_HOLD       = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        M0_HBUSREQ,
  output logic        M0_HGRANT,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [3:0]  M0_HPROT,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADY,
  output logic [31:0] M0_HRDATA,
  output logic        M0_HRESP,
  input  logic        M1_HBUSREQ,
  output logic        M1_HGRANT,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [3:0]  M1_HPROT,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADY,
  output logic [31:0] M1_HRDATA,
  output logic        M1_HRESP,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic        S_HREADY,
  input  logic [31:0] S_HRDATA,
  input  logic        S_HRESP,
  output logic        HMASTER
);

  localparam owner_e            DEF_OWNER  = (DEFAULT_MASTER != 0) ? OWN1 : OWN0;
  localparam logic [CNT_W-1:0]  MAX_HOLD_C = CNT_W'(MAX_HOLD);

  owner_e             addr_owner_q, addr_owner_d;
  owner_e             data_owner_q, data_owner_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  owner_e             next_owner;
  logic               other_req;
  logic               burst_lock;
  logic               hold_expired;
  logic               counts_phase;

  // Address-phase mux follows the registered owner; reset forces the default owner through.
  always_comb begin
    HADDR  = M0_HADDR;
    HTRANS = M0_HTRANS;
    HWRITE = M0_HWRITE;
    HSIZE  = M0_HSIZE;
    HPROT  = M0_HPROT;
    if (addr_owner_q == OWN1) begin
      HADDR  = M1_HADDR;
      HTRANS = M1_HTRANS;
      HWRITE = M1_HWRITE;
      HSIZE  = M1_HSIZE;
      HPROT  = M1_HPROT;
    end
  end

  assign HWDATA    = (data_owner_q == OWN1) ? M1_HWDATA : M0_HWDATA;
  assign M0_HRESP  = (data_owner_q == OWN0) ? S_HRESP : HRESP_OKAY;
  assign M1_HRESP  = (data_owner_q == OWN1) ? S_HRESP : HRESP_OKAY;
  assign M0_HREADY = S_HREADY;
  assign M1_HREADY = S_HREADY;
  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;
  assign M0_HGRANT = (addr_owner_q == OWN0);
  assign M1_HGRANT = (addr_owner_q == OWN1);
  assign HMASTER   = addr_owner_q;

  assign other_req    = (addr_owner_q == OWN0) ? M1_HBUSREQ : M0_HBUSREQ;
  assign burst_lock   = is_burst_cont(HTRANS);
  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == MAX_HOLD_C);
  assign counts_phase = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);

  ahb_arb_prio #(
    .DEFAULT_OWNER (DEF_OWNER),
    .RR_EN         (RR_EN != 0)
  ) u_prio (
    .req_i          ({M1_HBUSREQ, M0_HBUSREQ}),
    .owner_i        (addr_owner_q),
    .burst_lock_i   (burst_lock),
    .hold_expired_i (hold_expired),
    .next_owner_o   (next_owner)
  );

  // Next state: everything advances only on HREADY-high edges, wait states freeze it.
  always_comb begin
    addr_owner_d = addr_owner_q;
    data_owner_d = data_owner_q;
    hold_cnt_d   = hold_cnt_q;
    if (S_HREADY) begin
      addr_owner_d = next_owner;
      data_owner_d = addr_owner_q;
      if ((next_owner != addr_owner_q) || !other_req) begin
        hold_cnt_d = '0;
      end else if (counts_phase && (hold_cnt_q != MAX_HOLD_C)) begin
        hold_cnt_d = hold_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with asynchronous reset to the default owner.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_owner_q <= DEF_OWNER;
      data_owner_q <= DEF_OWNER;
      hold_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      addr_owner_q <= addr_owner_d;
      data_owner_q <= data_owner_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench: default, round-robin and MAX_HOLD=4 arbiters driven by one shared stimulus.
module tb_ahb_master_arbiter;
  import ahb_pkg::*;

  logic        HCLK, HRESET;
  logic        M0_HBUSREQ, M1_HBUSREQ;
  logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE;
  logic [2:0]  M0_HSIZE, M1_HSIZE;
  logic [3:0]  M0_HPROT, M1_HPROT;
  logic        S_HREADY, S_HRESP;
  logic [31:0] S_HRDATA;

  // Outputs of the default instance (a_), round-robin (r_) and MAX_HOLD=4 (h_).
  logic a_M0_HGRANT, a_M1_HGRANT, a_M0_HREADY, a_M1_HREADY, a_M0_HRESP, a_M1_HRESP, a_HWRITE, a_HMASTER;
  logic [31:0] a_M0_HRDATA, a_M1_HRDATA, a_HADDR, a_HWDATA;
  logic [1:0]  a_HTRANS;
  logic [2:0]  a_HSIZE;
  logic [3:0]  a_HPROT;
  logic r_M0_HGRANT, r_M1_HGRANT, r_M0_HREADY, r_M1_HREADY, r_M0_HRESP, r_M1_HRESP, r_HWRITE, r_HMASTER;
  logic [31:0] r_M0_HRDATA, r_M1_HRDATA, r_HADDR, r_HWDATA;
  logic [1:0]  r_HTRANS;
  logic [2:0]  r_HSIZE;
  logic [3:0]  r_HPROT;
  logic h_M0_HGRANT, h_M1_HGRANT, h_M0_HREADY, h_M1_HREADY, h_M0_HRESP, h_M1_HRESP, h_HWRITE, h_HMASTER;
  logic [31:0] h_M0_HRDATA, h_M1_HRDATA, h_HADDR, h_HWDATA;
  logic [1:0]  h_HTRANS;
  logic [2:0]  h_HSIZE;
  logic [3:0]  h_HPROT;

  int checks   = 0;
  int failures = 0;

  ahb_master_arbiter dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .M0_HBUSREQ(M0_HBUSREQ), .M0_HGRANT(a_M0_HGRANT), .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS),
    .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE), .M0_HPROT(M0_HPROT), .M0_HWDATA(M0_HWDATA),
    .M0_HREADY(a_M0_HREADY), .M0_HRDATA(a_M0_HRDATA), .M0_HRESP(a_M0_HRESP),
    .M1_HBUSREQ(M1_HBUSREQ), .M1_HGRANT(a_M1_HGRANT), .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS),
    .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE), .M1_HPROT(M1_HPROT), .M1_HWDATA(M1_HWDATA),
    .M1_HREADY(a_M1_HREADY), .M1_HRDATA(a_M1_HRDATA), .M1_HRESP(a_M1_HRESP),
    .HADDR(a_HADDR), .HTRANS(a_HTRANS), .HWRITE(a_HWRITE), .HSIZE(a_HSIZE), .HPROT(a_HPROT),
    .HWDATA(a_HWDATA), .S_HREADY(S_HREADY), .S_HRDATA(S_HRDATA), .S_HRESP(S_HRESP), .HMASTER(a_HMASTER)
  );

  ahb_master_arbiter #(.RR_EN(1)) dut_rr (
    .HCLK(HCLK), .HRESET(HRESET),
    .M0_HBUSREQ(M0_HBUSREQ), .M0_HGRANT(r_M0_HGRANT), .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS),
    .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE), .M0_HPROT(M0_HPROT), .M0_HWDATA(M0_HWDATA),
    .M0_HREADY(r_M0_HREADY), .M0_HRDATA(r_M0_HRDATA), .M0_HRESP(r_M0_HRESP),
    .M1_HBUSREQ(M1_HBUSREQ), .M1_HGRANT(r_M1_HGRANT), .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS),
    .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE), .M1_HPROT(M1_HPROT), .M1_HWDATA(M1_HWDATA),
    .M1_HREADY(r_M1_HREADY), .M1_HRDATA(r_M1_HRDATA), .M1_HRESP(r_M1_HRESP),
    .HADDR(r_HADDR), .HTRANS(r_HTRANS), .HWRITE(r_HWRITE), .HSIZE(r_HSIZE), .HPROT(r_HPROT),
    .HWDATA(r_HWDATA), .S_HREADY(S_HREADY), .S_HRDATA(S_HRDATA), .S_HRESP(S_HRESP), .HMASTER(r_HMASTER)
  );

  ahb_master_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut_h4 (
    .HCLK(HCLK), .HRESET(HRESET),
    .M0_HBUSREQ(M0_HBUSREQ), .M0_HGRANT(h_M0_HGRANT), .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS),
    .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE), .M0_HPROT(M0_HPROT), .M0_HWDATA(M0_HWDATA),
    .M0_HREADY(h_M0_HREADY), .M0_HRDATA(h_M0_HRDATA), .M0_HRESP(h_M0_HRESP),
    .M1_HBUSREQ(M1_HBUSREQ), .M1_HGRANT(h_M1_HGRANT), .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS),
    .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE), .M1_HPROT(M1_HPROT), .M1_HWDATA(M1_HWDATA),
    .M1_HREADY(h_M1_HREADY), .M1_HRDATA(h_M1_HRDATA), .M1_HRESP(h_M1_HRESP),
    .HADDR(h_HADDR), .HTRANS(h_HTRANS), .HWRITE(h_HWRITE), .HSIZE(h_HSIZE), .HPROT(h_HPROT),
    .HWDATA(h_HWDATA), .S_HREADY(S_HREADY), .S_HRDATA(S_HRDATA), .S_HRESP(S_HRESP), .HMASTER(h_HMASTER)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One bus cycle: active edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESET = 1'b1;
    M0_HBUSREQ = 1'b0; M1_HBUSREQ = 1'b0;
    M0_HADDR = 32'h0000_1234; M1_HADDR = 32'h0;
    M0_HTRANS = HTRANS_IDLE; M1_HTRANS = HTRANS_IDLE;
    M0_HWRITE = 1'b0; M1_HWRITE = 1'b0;
    M0_HSIZE = 3'd2; M1_HSIZE = 3'd2;
    M0_HPROT = 4'h3; M1_HPROT = 4'h3;
    M0_HWDATA = 32'h0; M1_HWDATA = 32'h0;
    S_HREADY = 1'b1; S_HRESP = 1'b0; S_HRDATA = 32'hCAFE_0001;

    // Reset state and combinational pass-through of the default master.
    tick();
    check("rst_m0_grant", a_M0_HGRANT, 1);
    check("rst_m1_grant", a_M1_HGRANT, 0);
    check("rst_hmaster", a_HMASTER, 0);
    check("rst_htrans", a_HTRANS, HTRANS_IDLE);
    check("rst_haddr_pass", a_HADDR, 32'h0000_1234);
    check("rst_hold_cnt", dut.hold_cnt_q, 0);
    check("rdata_pass_m0", a_M0_HRDATA, 32'hCAFE_0001);
    check("rdata_pass_m1", a_M1_HRDATA, 32'hCAFE_0001);
    tick();
    HRESET = 1'b0;
    M0_HADDR = 32'h0;

    // M1 single write: grant at first edge, address next cycle, data after.
    M1_HBUSREQ = 1'b1;
    tick();
    check("single_m1_grant", a_M1_HGRANT, 1);
    check("single_hmaster", a_HMASTER, 1);
    M1_HTRANS = HTRANS_NONSEQ; M1_HADDR = 32'h4005_0000; M1_HWRITE = 1'b1;
    M1_HBUSREQ = 1'b0;
    #1;
    check("single_haddr", a_HADDR, 32'h4005_0000);
    check("single_htrans", a_HTRANS, HTRANS_NONSEQ);
    check("single_hwrite", a_HWRITE, 1);
    tick();
    M1_HTRANS = HTRANS_IDLE; M1_HWDATA = 32'hA5A5_A5A5; S_HRESP = 1'b1;
    #1;
    check("single_hwdata", a_HWDATA, 32'hA5A5_A5A5);
    check("single_m0_hresp", a_M0_HRESP, 0);
    check("single_m1_hresp", a_M1_HRESP, 1);
    check("single_back_default", a_M0_HGRANT, 1);
    S_HRESP = 1'b0; M1_HWRITE = 1'b0;

    // M1 4-beat INCR burst; M0 requests at beat 2 and must wait for the burst end.
    M1_HBUSREQ = 1'b1;
    tick();
    check("burst_m1_grant", a_M1_HGRANT, 1);
    for (int beat = 0; beat < 4; beat++) begin
      M1_HTRANS = (beat == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
      M1_HADDR  = 32'h2000_0000 + 32'(beat * 4);
      if (beat == 1) M0_HBUSREQ = 1'b1;
      #1;
      check("burst_haddr", a_HADDR, 32'h2000_0000 + 32'(beat * 4));
      tick();
      check("burst_m1_keeps", a_M1_HGRANT, 1);
    end
    M1_HTRANS = HTRANS_IDLE; M1_HBUSREQ = 1'b0;
    tick();
    check("burst_m0_after", a_M0_HGRANT, 1);
    check("burst_hmaster", a_HMASTER, 0);

    // Wait states during an M1 data phase freeze grant and data ownership.
    M0_HBUSREQ = 1'b0; M1_HBUSREQ = 1'b1;
    tick();
    check("wait_m1_grant", a_M1_HGRANT, 1);
    M1_HTRANS = HTRANS_NONSEQ; M1_HADDR = 32'h4005_0010; M1_HWRITE = 1'b1;
    tick();
    M1_HTRANS = HTRANS_IDLE; M1_HWDATA = 32'h1111_1111; M0_HWDATA = 32'hDEAD_BEEF;
    M0_HBUSREQ = 1'b1; S_HREADY = 1'b0;
    for (int w = 0; w < 3; w++) begin
      tick();
      check("wait_m1_grant_hold", a_M1_HGRANT, 1);
      check("wait_data_owner", dut.data_owner_q, 1);
      check("wait_hwdata", a_HWDATA, 32'h1111_1111);
      check("wait_hready_pass", a_M0_HREADY, 0);
    end
    S_HREADY = 1'b1;
    tick();
    check("wait_m0_granted", a_M0_HGRANT, 1);
    check("wait_m1_released", a_M1_HGRANT, 0);
    check("wait_data_owner_end", dut.data_owner_q, 1);

    // Reset while M1 owns the bus returns ownership immediately.
    M0_HBUSREQ = 1'b0;
    tick();
    check("prereset_hmaster", a_HMASTER, 1);
    #2;
    HRESET = 1'b1;
    #1;
    check("midreset_hmaster", a_HMASTER, 0);
    check("midreset_m0_grant", a_M0_HGRANT, 1);

    // Both request continuously with NONSEQ singles: RR alternates, MAX_HOLD=4 hands over.
    M0_HBUSREQ = 1'b1; M1_HBUSREQ = 1'b1;
    M0_HTRANS = HTRANS_NONSEQ; M0_HADDR = 32'h2000_0100;
    M1_HTRANS = HTRANS_NONSEQ; M1_HADDR = 32'h4005_0100;
    tick();
    HRESET = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("rr_hmaster", r_HMASTER, (i % 2 == 1) ? 1 : 0);
      check("rr_haddr", r_HADDR, (i % 2 == 1) ? 32'h4005_0100 : 32'h2000_0100);
      check("hold4_hmaster", h_HMASTER, (i == 5) ? 1 : 0);
      check("hold4_cnt", dut_h4.hold_cnt_q, (i <= 4) ? i : 0);
      check("hold16_hmaster", a_HMASTER, 0);
      check("hold16_cnt", dut.hold_cnt_q, i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
